// File: rtl/clyde_ctrl_pkg.sv
// Clyde-128 W/TK sequencer: FSM states, round-constant values and helpers.
// Shared by clyde_w_lfsr and clyde_addwtk_ctrl.
package clyde_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TK0,
    LAYER,
    ADD,
    TKF,
    DONE
  } state_t;

  localparam logic [3:0] W_INIT = 4'h1;
  localparam logic [3:0] W_POLY = 4'h3;
  localparam logic [3:0] W_LAST = 4'hE;
  localparam int NROUNDS_DEF = 12;

  function automatic logic [3:0] w_fwd(input logic [3:0] c);
    return {c[2:0], 1'b0} ^ (c[3] ? W_POLY : 4'h0);
  endfunction

  function automatic logic [3:0] w_inv(input logic [3:0] c);
    return c[0] ? (((c ^ W_POLY) >> 1) | 4'h8) : (c >> 1);
  endfunction

  function automatic logic [1:0] ph_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [1:0] ph_dec(input logic [1:0] p);
    return (p == 2'd0) ? 2'd2 : p - 2'd1;
  endfunction

endpackage

// File: rtl/clyde_w_lfsr.sv
// 4-bit Clyde round-constant LFSR.
// dir=0 steps forward from W_INIT, dir=1 steps backward from W_LAST.
module clyde_w_lfsr
  import clyde_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic       dir,
  output logic [3:0] w
);

  always_ff @(posedge clk) begin
    if (rst) begin
      w <= W_INIT;
    end else if (load) begin
      w <= dir ? W_LAST : W_INIT;
    end else if (step) begin
      w <= dir ? w_inv(w) : w_fwd(w);
    end
  end

endmodule

// File: rtl/clyde_addwtk_ctrl.sv
// Masked Clyde-128 round sequencer: layer handshake, W constant, tweak delta.
// Define CLYDE_DECRYPT_EN to add the `inverse` port and the decryption schedule.
module clyde_addwtk_ctrl
  import clyde_ctrl_pkg::*;
#(
  parameter int Nbits   = 128,
  parameter int NROUNDS = NROUNDS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef CLYDE_DECRYPT_EN
  input  logic             inverse,
`endif
  input  logic [Nbits-1:0] tweak_in,
  output logic             busy,
  output logic             done,
  output logic             layer_start,
  input  logic             layer_done,
  output logic             state_en,
  output logic             ctrl_TK_addition,
  output logic             ctrl_W_addition,
  output logic [3:0]       W,
  output logic [Nbits-1:0] delta
);

  localparam int RW = $clog2(NROUNDS + 1);
  localparam int H  = Nbits / 2;
  localparam logic [RW-1:0] R_LAST = RW'(NROUNDS - 1);
  localparam logic [RW-1:0] R_END  = RW'(NROUNDS);

  state_t           state_q;
  state_t           state_d;
  logic [RW-1:0]    round_q;
  logic [RW-1:0]    r_rev;
  logic [1:0]       phase_q;
  logic [1:0]       phase_cur;
  logic [Nbits-1:0] tweak_q;
  logic [H-1:0]     t0;
  logic [H-1:0]     t1;
  logic             in_layer_q;
  logic             inv_q;
  logic             inv_in;
  logic             accept;
  logic             lay_ok;
  logic             tk_add;

`ifdef CLYDE_DECRYPT_EN
  assign inv_in = inverse;
`else
  assign inv_in = 1'b0;
`endif

  assign accept = (state_q == IDLE) && start;
  assign layer_start = (state_q == LAYER) && !in_layer_q;
  // completion is only taken after the layer_start cycle
  assign lay_ok = (state_q == LAYER) && in_layer_q && layer_done;

  assign r_rev  = R_LAST - round_q;
  assign tk_add = inv_q ? (r_rev[0] && (round_q != '0))
                        : round_q[0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = TK0;
      TK0:   state_d = inv_q ? ADD : LAYER;
      LAYER: begin
        if (lay_ok) begin
          if (inv_q && (round_q == R_END)) state_d = TKF;
          else                             state_d = ADD;
        end
      end
      ADD: begin
        if (!inv_q && (round_q == R_LAST)) state_d = DONE;
        else                               state_d = LAYER;
      end
      TKF:   state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy             = (state_q != IDLE);
    done             = 1'b0;
    state_en         = 1'b0;
    ctrl_TK_addition = 1'b0;
    ctrl_W_addition  = 1'b0;
    phase_cur        = phase_q;
    unique case (state_q)
      TK0: begin
        state_en         = 1'b1;
        ctrl_TK_addition = 1'b1;
      end
      ADD: begin
        state_en         = 1'b1;
        ctrl_W_addition  = 1'b1;
        ctrl_TK_addition = tk_add;
        // a tweakey ADD already uses the advanced tweak phase
        if (tk_add) phase_cur = inv_q ? ph_dec(phase_q) : ph_inc(phase_q);
      end
      TKF: begin
        state_en         = 1'b1;
        ctrl_TK_addition = 1'b1;
        phase_cur        = 2'd0;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_q    <= '0;
      phase_q    <= 2'd0;
      tweak_q    <= '0;
      inv_q      <= 1'b0;
      in_layer_q <= 1'b0;
    end else begin
      in_layer_q <= (state_q == LAYER);
      if (accept) begin
        tweak_q <= tweak_in;
        inv_q   <= inv_in;
        round_q <= '0;
        phase_q <= 2'd0;
      end
      if (state_q == ADD) begin
        round_q <= round_q + RW'(1);
        phase_q <= phase_cur;
      end
      if (state_q == TKF) phase_q <= 2'd0;
    end
  end

  assign t1 = tweak_q[Nbits-1:H];
  assign t0 = tweak_q[H-1:0];

  always_comb begin
    unique case (phase_cur)
      2'd1:    delta = {t0 ^ t1, t0};
      2'd2:    delta = {t1, t0 ^ t1};
      default: delta = {t1, t0};
    endcase
  end

  clyde_w_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .step (state_q == ADD),
    .dir  (accept ? inv_in : inv_q),
    .w    (W)
  );

endmodule

// File: tb/tb_clyde_addwtk_ctrl.sv
// Directed bench for clyde_addwtk_ctrl: schedule, handshake, abort, latency.
// Decryption checks are built when CLYDE_DECRYPT_EN is defined.
module tb_clyde_addwtk_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] tweak_in;
  logic         busy;
  logic         done;
  logic         layer_start;
  logic         layer_done;
  logic         state_en;
  logic         ctrl_TK_addition;
  logic         ctrl_W_addition;
  logic [3:0]   W;
  logic [127:0] delta;
`ifdef CLYDE_DECRYPT_EN
  logic         inverse;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int lat_done;
  int n_en;
  int n_ls;
  int n_dn;
  bit aborted;
  logic [3:0]   w_q[$];
  logic         tk_q[$];
  logic [127:0] dl_q[$];

  logic [3:0] w_enc[12] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6,
                            4'hC, 4'hB, 4'h5, 4'hA, 4'h7, 4'hE};
  int ph_enc[7] = '{0, 1, 2, 0, 1, 2, 0};

  localparam logic [127:0] T_A = 128'h0123456789ABCDEF_0F1E2D3C4B5A69EF;
  localparam logic [127:0] T_B = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};

  clyde_addwtk_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
`ifdef CLYDE_DECRYPT_EN
    .inverse          (inverse),
`endif
    .tweak_in         (tweak_in),
    .busy             (busy),
    .done             (done),
    .layer_start      (layer_start),
    .layer_done       (layer_done),
    .state_en         (state_en),
    .ctrl_TK_addition (ctrl_TK_addition),
    .ctrl_W_addition  (ctrl_W_addition),
    .W                (W),
    .delta            (delta)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_delta(input logic [127:0] t,
                                             input int ph);
    logic [63:0] a;
    logic [63:0] b;
    a = t[127:64];
    b = t[63:0];
    case (ph)
      1:       return {a ^ b, b};
      2:       return {a, a ^ b};
      default: return {a, b};
    endcase
  endfunction

  // One call from a negedge in IDLE; layer_done answers lat cycles of LAYER.
  task automatic run_call(input int lat, input int hold, input bit inv,
                          input bit poke, input int abort_ls);
    int cd;
    int hc;
    int c;
    cd = -1;
    hc = 0;
    lat_done = -1;
    n_en = 0;
    n_ls = 0;
    aborted = 0;
    w_q.delete();
    tk_q.delete();
    dl_q.delete();
    start = 1'b1;
`ifdef CLYDE_DECRYPT_EN
    inverse = inv;
`else
    if (inv) $display("note: inverse call skipped in this build");
`endif
    @(negedge clk);
    start = 1'b0;
    tweak_in = ~tweak_in;
    c = 1;
    while (c < 400 && lat_done < 0 && !aborted) begin
      if (state_en) n_en++;
      if (ctrl_W_addition) begin
        w_q.push_back(W);
        tk_q.push_back(ctrl_TK_addition);
      end
      if (ctrl_TK_addition) dl_q.push_back(delta);
      if (layer_start) n_ls++;
      if (done) lat_done = c;
      if (abort_ls != 0 && n_ls == abort_ls) begin
        rst = 1'b1;
        aborted = 1;
      end
      if (layer_start) cd = lat - 1;
      else if (cd >= 0) cd--;
      if (cd == 0) hc = hold;
      layer_done = (hc > 0);
      if (hc > 0) hc--;
      start = poke && (c == 5 || c == 6 || c == 20 || done);
      @(negedge clk);
      c++;
    end
    layer_done = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    layer_done = 1'b0;
    tweak_in = '0;
`ifdef CLYDE_DECRYPT_EN
    inverse = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_lstart", 128'(layer_start), 128'(0));
    chk("rst_en", 128'(state_en), 128'(0));
    chk("rst_tk", 128'(ctrl_TK_addition), 128'(0));
    chk("rst_w_add", 128'(ctrl_W_addition), 128'(0));
    chk("rst_W", 128'(W), 128'h1);
    chk("rst_delta", delta, 128'h0);

    start = 1'b1;
    @(negedge clk);
    chk("rst_beats_start", 128'(busy), 128'(0));
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 128'(busy), 128'(0));

    // encryption, one-cycle layer response
    tweak_in = T_A;
    run_call(2, 1, 0, 0, 0);
    chk("enc_latency", 128'(lat_done), 128'(38));
    chk("enc_en_cnt", 128'(n_en), 128'(13));
    chk("enc_ls_cnt", 128'(n_ls), 128'(12));
    chk("enc_add_cnt", 128'(w_q.size()), 128'(12));
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("enc_w%0d", i), 128'(w_q[i]), 128'(w_enc[i]));
      chk($sformatf("enc_tk%0d", i), 128'(tk_q[i]), 128'(i % 2));
    end
    chk("enc_tk_uses", 128'(dl_q.size()), 128'(7));
    for (int i = 0; i < 7; i++)
      chk($sformatf("enc_delta%0d", i), dl_q[i], exp_delta(T_A, ph_enc[i]));
    chk("enc_done_pulse", 128'(done), 128'(0));
    chk("enc_back_idle", 128'(busy), 128'(0));

    // delta patterns with T1 all ones, T0 zero
    tweak_in = T_B;
    run_call(2, 1, 0, 0, 0);
    chk("tb_latency", 128'(lat_done), 128'(38));
    chk("tb_ph0", dl_q[0], {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    chk("tb_ph1", dl_q[1], {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    chk("tb_ph2", dl_q[2], {128{1'b1}});

    // layer_done kept high, extra starts while busy and in DONE
    tweak_in = T_A;
    run_call(2, 5, 0, 1, 0);
    chk("hold_latency", 128'(lat_done), 128'(38));
    chk("hold_add_cnt", 128'(w_q.size()), 128'(12));
    chk("hold_ls_cnt", 128'(n_ls), 128'(12));
    chk("hold_en_cnt", 128'(n_en), 128'(13));
    chk("hold_w11", 128'(w_q[11]), 128'hE);
    chk("poke_idle", 128'(busy), 128'(0));

    // reset in the round-6 layer
    tweak_in = T_A;
    run_call(2, 1, 0, 0, 7);
    chk("abort_seen", 128'(aborted), 128'(1));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_W", 128'(W), 128'h1);
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_en", 128'(state_en), 128'(0));
    chk("abort_delta", delta, 128'h0);
    rst = 1'b0;
    n_dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) n_dn++;
    end
    chk("abort_quiet", 128'(n_dn), 128'(0));

    // seven-cycle layer
    tweak_in = T_B;
    run_call(7, 1, 0, 0, 0);
    chk("lay7_latency", 128'(lat_done), 128'(98));
    chk("lay7_en_cnt", 128'(n_en), 128'(13));
    chk("lay7_ls_cnt", 128'(n_ls), 128'(12));

`ifdef CLYDE_DECRYPT_EN
    begin
      logic [3:0] w_dec[12] = '{4'hE, 4'h7, 4'hA, 4'h5, 4'hB, 4'hC,
                                4'h6, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1};
      int ph_dec[7] = '{0, 2, 1, 0, 2, 1, 0};
      tweak_in = T_A;
      run_call(2, 1, 1, 0, 0);
      chk("dec_latency", 128'(lat_done), 128'(39));
      chk("dec_en_cnt", 128'(n_en), 128'(14));
      chk("dec_add_cnt", 128'(w_q.size()), 128'(12));
      for (int i = 0; i < 12; i++) begin
        chk($sformatf("dec_w%0d", i), 128'(w_q[i]), 128'(w_dec[i]));
        chk($sformatf("dec_tk%0d", i), 128'(tk_q[i]),
            128'((i > 0) && (i % 2 == 0)));
      end
      chk("dec_tk_uses", 128'(dl_q.size()), 128'(7));
      for (int i = 0; i < 7; i++)
        chk($sformatf("dec_delta%0d", i), dl_q[i],
            exp_delta(T_A, ph_dec[i]));
      inverse = 1'b0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
